// File: rtl/dtree_pkg.sv
// Shared types, default widths and node-table helpers for the decision-tree sequencer.
package dtree_pkg;

  localparam int N_FEAT_D    = 7;
  localparam int FEAT_W_D    = 8;
  localparam int CLASS_W_D   = 5;
  localparam int N_NODES_D   = 16;
  localparam int MAX_DEPTH_D = 15;

  localparam int IDX_W   = $clog2(N_FEAT_D);
  // keep holds 1..FEAT_W, so it needs one bit more than log2(FEAT_W)
  localparam int KEEP_W  = $clog2(FEAT_W_D) + 1;
  // Child pointers carry one extra bit so an out-of-table child is representable
  localparam int CHILD_W = $clog2(N_NODES_D) + 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                       is_leaf;
    logic [IDX_W-1:0]           feat_idx;
    logic [KEEP_W-1:0]          keep;
    logic signed [FEAT_W_D-1:0] thr;
    logic [CHILD_W-1:0]         left;
    logic [CHILD_W-1:0]         right;
    logic [CLASS_W_D-1:0]       cls;
  } node_t;

  typedef node_t [N_NODES_D-1:0] node_tbl_t;

  function automatic node_t mk_split(int f, int k, int t, int l, int r);
    node_t n;
    n          = '0;
    n.feat_idx = IDX_W'(f);
    n.keep     = KEEP_W'(k);
    n.thr      = FEAT_W_D'(t);
    n.left     = CHILD_W'(l);
    n.right    = CHILD_W'(r);
    return n;
  endfunction

  function automatic node_t mk_leaf(int c);
    node_t n;
    n         = '0;
    n.is_leaf = 1'b1;
    n.cls     = CLASS_W_D'(c);
    return n;
  endfunction

  // Small reference tree: feature 6, top 3 bits, <= 0 -> class 5, else class 9
  function automatic node_tbl_t default_table();
    node_tbl_t t;
    t    = '0;
    t[0] = mk_split(6, 3, 0, 1, 2);
    t[1] = mk_leaf(5);
    t[2] = mk_leaf(9);
    return t;
  endfunction

endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node table, contents fixed by parameter at elaboration.
module dtree_node_rom
  import dtree_pkg::*;
#(
  parameter int        N_NODES    = N_NODES_D,
  parameter node_tbl_t NODE_TABLE = default_table()
) (
  input  logic [$clog2(N_NODES)-1:0] node_idx_i,
  output node_t                      node_o
);

  // Pure table lookup of the current node
  always_comb node_o = NODE_TABLE[node_idx_i];

endmodule

// File: rtl/dtree_seq_ctrl.sv
// Decision-tree classifier sequencer: loads one feature vector, walks the node
// table one node per cycle through a single shared comparator, holds the result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOAD    | accepting feature words into feat_q, cnt counts transfers
// WALK    | evaluating one node per cycle, depth tracks comparisons
// DONE    | result held on res_*, waiting for res_ready
module dtree_seq_ctrl
  import dtree_pkg::*;
#(
  parameter int        N_FEAT     = N_FEAT_D,
  parameter int        FEAT_W     = FEAT_W_D,
  parameter int        CLASS_W    = CLASS_W_D,
  parameter int        N_NODES    = N_NODES_D,
  parameter int        MAX_DEPTH  = MAX_DEPTH_D,
  parameter node_tbl_t NODE_TABLE = default_table()
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               feat_valid,
  output logic               feat_ready,
  input  logic [FEAT_W-1:0]  feat_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CLASS_W-1:0] res_class,
  output logic               res_err,
  output logic               busy
);

  localparam int NID_W   = $clog2(N_NODES);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int CNT_W   = $clog2(N_FEAT);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NID_W-1:0]     node_q;
  logic                 bad_q;
  logic [DEPTH_W-1:0]   depth_q;
  logic [FEAT_W-1:0]    feat_q [N_FEAT];
  logic                 feat_ready_q;
  logic                 res_valid_q;
  logic [CLASS_W-1:0]   res_class_q;
  logic                 res_err_q;
  logic                 busy_q;

  node_t                cur;
  logic [FEAT_W-1:0]    feat_sel;
  logic [KEEP_W-1:0]    shamt;
  logic signed [FEAT_W-1:0] feat_ext;
  logic                 go_left;
  logic [CHILD_W-1:0]   nxt_child;
  logic                 child_oob;

  dtree_node_rom #(
    .N_NODES    (N_NODES),
    .NODE_TABLE (NODE_TABLE)
  ) u_rom (
    .node_idx_i (node_q),
    .node_o     (cur)
  );

  // Shared comparator: truncate the selected feature to its top keep bits
  // (arithmetic shift keeps the sign), then compare signed against thr.
  always_comb begin
    feat_sel = '0;
    if (int'(cur.feat_idx) < N_FEAT) feat_sel = feat_q[cur.feat_idx];
    // keep of 0 or above FEAT_W is malformed; fall back to the sign bit only
    if (cur.keep == '0 || int'(cur.keep) > FEAT_W) shamt = KEEP_W'(FEAT_W - 1);
    else                                           shamt = KEEP_W'(FEAT_W) - cur.keep;
    feat_ext  = $signed(feat_sel) >>> shamt;
    go_left   = (feat_ext <= $signed(cur.thr));
    nxt_child = go_left ? cur.left : cur.right;
    child_oob = (nxt_child >= CHILD_W'(N_NODES));
  end

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      node_q       <= '0;
      bad_q        <= 1'b0;
      depth_q      <= '0;
      feat_ready_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_class_q  <= '0;
      res_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) feat_q[i] <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (feat_valid) begin
            feat_q[cnt_q] <= feat_data;
            if (cnt_q == CNT_W'(N_FEAT - 1)) begin
              cnt_q        <= '0;
              node_q       <= '0;
              bad_q        <= 1'b0;
              depth_q      <= '0;
              feat_ready_q <= 1'b0;
              busy_q       <= 1'b1;
              state_q      <= ST_WALK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_WALK: begin
          // An out-of-table child was taken last cycle: same outcome as depth exhaustion
          if (bad_q || (!cur.is_leaf && depth_q == DEPTH_W'(MAX_DEPTH))) begin
            res_class_q <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (cur.is_leaf) begin
            res_class_q <= cur.cls;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            depth_q <= depth_q + 1'b1;
            if (child_oob) bad_q  <= 1'b1;
            else           node_q <= nxt_child[NID_W-1:0];
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_q  <= 1'b0;
            feat_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_LOAD;
          end
        end
        default: begin
          state_q      <= ST_LOAD;
          feat_ready_q <= 1'b1;
          res_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          cnt_q        <= '0;
        end
      endcase
    end
  end

  assign feat_ready = feat_ready_q;
  assign res_valid  = res_valid_q;
  assign res_class  = res_class_q;
  assign res_err    = res_err_q;
  assign busy       = busy_q;

endmodule
